// File: rtl/riscv_isa_pkg.sv
// riscv_isa_pkg
//   Shared RV32I definitions for the decode/issue slice: major opcode
//   constants, funct7 values, reference alu_op encodings, immediate-format
//   enum, skid-buffer occupancy states and the alu_op packing helper.
//   No ports (package).
package riscv_isa_pkg;

    localparam logic [6:0] TYPE_LUI    = 7'b0110111;
    localparam logic [6:0] TYPE_AUIPC  = 7'b0010111;
    localparam logic [6:0] TYPE_JAL    = 7'b1101111;
    localparam logic [6:0] TYPE_JALR   = 7'b1100111;
    localparam logic [6:0] TYPE_BRANCH = 7'b1100011;
    localparam logic [6:0] TYPE_LOAD   = 7'b0000011;
    localparam logic [6:0] TYPE_STORE  = 7'b0100011;
    localparam logic [6:0] TYPE_OP_IMM = 7'b0010011;
    localparam logic [6:0] TYPE_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    localparam logic [15:0] ALU_OP_ADDI    = 16'h0013;
    localparam logic [15:0] ALU_OP_SUB     = 16'h8033;
    localparam logic [15:0] ALU_OP_SRAI    = 16'h8293;
    localparam logic [15:0] ALU_OP_LUI     = 16'h0037;
    localparam logic [15:0] ALU_OP_ILLEGAL = 16'h0000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_type_e;

    // Number of entries held by the issue skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_e;

    // Normalised ALU op: {funct7[5:0], funct3, opcode}.
    function automatic logic [15:0] pack_alu_op(input logic [5:0] f7,
                                                input logic [2:0] f3,
                                                input logic [6:0] opc);
        return {f7, f3, opc};
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder
//   Purely combinational RV32I decoder: turns one instruction word plus its
//   PC and register read data into ALU op, operands and writeback control.
//   Ports:
//     instr     in   32  instruction word
//     pc        in   DW  PC of instr
//     rs1_data  in   DW  register file read data 1
//     rs2_data  in   DW  register file read data 2
//     alu_op    out  16  normalised op (0 when illegal)
//     alu_a     out  DW  operand A
//     alu_b     out  DW  operand B
//     rd_addr   out  5   destination register
//     rd_we     out  1   writeback enable
//     is_branch out  1   conditional branch
//     illegal   out  1   undecodable instruction
module rv32i_decoder
    import riscv_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic [15:0]           alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            rd_addr,
    output logic                  rd_we,
    output logic                  is_branch,
    output logic                  illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd_addr = instr[11:7];

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Sign-extends a 32-bit immediate to the datapath width.
    function automatic logic [DATA_WIDTH-1:0] sext(input logic signed [31:0] v);
        return DATA_WIDTH'(v);
    endfunction

    imm_type_e             imm_sel;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic                  a_from_pc, a_zero, b_from_rs2;
    logic                  keep_f7, keep_f3, writes_rd, branch, bad;

    always_comb begin
        imm_sel    = IMM_NONE;
        a_from_pc  = 1'b0;
        a_zero     = 1'b0;
        b_from_rs2 = 1'b0;
        keep_f7    = 1'b0;
        keep_f3    = 1'b1;
        writes_rd  = 1'b1;
        branch     = 1'b0;
        bad        = 1'b0;
        case (opcode)
            TYPE_OP: begin
                b_from_rs2 = 1'b1;
                keep_f7    = 1'b1;
                if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
                    bad = 1'b1;
                else if (funct7 == FUNCT7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
                    bad = 1'b1;
            end
            TYPE_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    imm_sel = IMM_SHAMT;
                    bad     = (funct7 != FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    // SRLI/SRAI keep funct7 to distinguish logical/arithmetic.
                    imm_sel = IMM_SHAMT;
                    keep_f7 = 1'b1;
                    bad     = (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT);
                end else begin
                    imm_sel = IMM_I;
                end
            end
            TYPE_LOAD:   imm_sel = IMM_I;
            TYPE_JALR: begin
                imm_sel = IMM_I;
                keep_f3 = 1'b0;
            end
            TYPE_STORE: begin
                imm_sel   = IMM_S;
                writes_rd = 1'b0;
            end
            TYPE_BRANCH: begin
                imm_sel   = IMM_B;
                a_from_pc = 1'b1;
                writes_rd = 1'b0;
                branch    = 1'b1;
            end
            TYPE_LUI: begin
                imm_sel = IMM_U;
                a_zero  = 1'b1;
                keep_f3 = 1'b0;
            end
            TYPE_AUIPC: begin
                imm_sel   = IMM_U;
                a_from_pc = 1'b1;
                keep_f3   = 1'b0;
            end
            TYPE_JAL: begin
                imm_sel   = IMM_J;
                a_from_pc = 1'b1;
                keep_f3   = 1'b0;
            end
            default: begin
                bad       = 1'b1;
                writes_rd = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (imm_sel)
            IMM_I:     imm_ext = sext(imm_i);
            IMM_S:     imm_ext = sext(imm_s);
            IMM_B:     imm_ext = sext(imm_b);
            IMM_U:     imm_ext = sext(imm_u);
            IMM_J:     imm_ext = sext(imm_j);
            IMM_SHAMT: imm_ext = DATA_WIDTH'(instr[24:20]);
            default:   imm_ext = '0;
        endcase
    end

    assign alu_a     = a_zero ? '0 : (a_from_pc ? pc : rs1_data);
    assign alu_b     = b_from_rs2 ? rs2_data : imm_ext;
    assign alu_op    = bad ? ALU_OP_ILLEGAL
                           : pack_alu_op(keep_f7 ? funct7[5:0] : 6'b0,
                                         keep_f3 ? funct3 : 3'b0, opcode);
    assign rd_we     = writes_rd & ~bad & (rd_addr != 5'd0);
    assign is_branch = branch;
    assign illegal   = bad;

endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage
//   Decode/issue stage in front of the integer ALU. Decodes the offered
//   instruction at accept time and holds up to two decoded entries (main
//   output register + skid register) so stalls on either side never drop work.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid/in_ready     fetch handshake; in_instr, in_pc payload
//     rs1_addr/rs2_addr     regfile read addresses (combinational)
//     rs1_data/rs2_data     same-cycle regfile read data
//     flush                 drop every held and offered instruction
//     out_valid/out_ready   execute handshake
//     alu_e, alu_op, alu_a, alu_b, cmp_a, cmp_b, rd_addr, rd_we,
//     is_branch, out_pc, illegal   issued instruction fields
module decode_issue_stage
    import riscv_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_e,
    output logic [15:0]           alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [DATA_WIDTH-1:0] cmp_a,
    output logic [DATA_WIDTH-1:0] cmp_b,
    output logic [4:0]            rd_addr,
    output logic                  rd_we,
    output logic                  is_branch,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  illegal
);

    typedef struct packed {
        logic [15:0]           alu_op;
        logic [DATA_WIDTH-1:0] alu_a;
        logic [DATA_WIDTH-1:0] alu_b;
        logic [DATA_WIDTH-1:0] cmp_a;
        logic [DATA_WIDTH-1:0] cmp_b;
        logic [DATA_WIDTH-1:0] pc;
        logic [4:0]            rd_addr;
        logic                  rd_we;
        logic                  is_branch;
        logic                  illegal;
    } entry_t;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    logic [15:0]           d_alu_op;
    logic [DATA_WIDTH-1:0] d_alu_a, d_alu_b;
    logic [4:0]            d_rd_addr;
    logic                  d_rd_we, d_is_branch, d_illegal;

    rv32i_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_decoder (
        .instr     (in_instr),
        .pc        (in_pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .alu_op    (d_alu_op),
        .alu_a     (d_alu_a),
        .alu_b     (d_alu_b),
        .rd_addr   (d_rd_addr),
        .rd_we     (d_rd_we),
        .is_branch (d_is_branch),
        .illegal   (d_illegal)
    );

    entry_t dec_p0;

    always_comb begin
        dec_p0           = '0;
        dec_p0.alu_op    = d_alu_op;
        dec_p0.alu_a     = d_alu_a;
        dec_p0.alu_b     = d_alu_b;
        dec_p0.cmp_a     = rs1_data;
        dec_p0.cmp_b     = rs2_data;
        dec_p0.pc        = in_pc;
        dec_p0.rd_addr   = d_rd_addr;
        dec_p0.rd_we     = d_rd_we;
        dec_p0.is_branch = d_is_branch;
        dec_p0.illegal   = d_illegal;
    end

    // ---- p0 -> p1: skid buffer (main_p1 drives outputs, skid_p1 holds overflow)
    skid_state_e state;
    entry_t      main_p1, skid_p1;
    logic        accept, issue;

    assign in_ready  = ~reset & (state != SKID_TWO);
    assign out_valid = (state != SKID_EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SKID_EMPTY;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else if (flush) begin
            // Flush outranks both handshakes; the offered instruction is dropped.
            state <= SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_p1 <= dec_p0;
                        state   <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && !issue) begin
                        skid_p1 <= dec_p0;
                        state   <= SKID_TWO;
                    end else if (accept && issue) begin
                        main_p1 <= dec_p0;
                    end else if (issue) begin
                        state <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (issue) begin
                        main_p1 <= skid_p1;
                        state   <= SKID_ONE;
                    end
                end
                default: state <= SKID_EMPTY;
            endcase
        end
    end

    assign alu_e     = out_valid & ~main_p1.illegal;
    assign alu_op    = main_p1.alu_op;
    assign alu_a     = main_p1.alu_a;
    assign alu_b     = main_p1.alu_b;
    assign cmp_a     = main_p1.cmp_a;
    assign cmp_b     = main_p1.cmp_b;
    assign rd_addr   = main_p1.rd_addr;
    assign rd_we     = main_p1.rd_we;
    assign is_branch = main_p1.is_branch;
    assign out_pc    = main_p1.pc;
    assign illegal   = main_p1.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage
//   Directed-vector bench for decode_issue_stage with hand-computed expectations.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        alu_e;
    logic [15:0] alu_op;
    logic [31:0] alu_a, alu_b, cmp_a, cmp_b, out_pc;
    logic [4:0]  rd_addr;
    logic        rd_we, is_branch, illegal;

    int vectors = 0;
    int miscompares = 0;

    decode_issue_stage #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_e     (alu_e),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .rd_addr   (rd_addr),
        .rd_we     (rd_we),
        .is_branch (is_branch),
        .out_pc    (out_pc),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b1; out_ready = 1'b1;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        vectors++; if (alu_op !== 16'h0) begin miscompares++; $display("FAIL reset_alu_op got %h want 0000", alu_op); end
        vectors++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin miscompares++; $display("FAIL reset_operands got %h/%h want 0/0", alu_a, alu_b); end
        vectors++; if (rd_we !== 1'b0 || alu_e !== 1'b0) begin miscompares++; $display("FAIL reset_enables got %b%b want 00", rd_we, alu_e); end
        reset = 1'b0; flush = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'h0; rs1_data = 32'd10; rs2_data = 32'd0;
        #1;
        vectors++; if (rs1_addr !== 5'd2) begin miscompares++; $display("FAIL addi_rs1_addr got %0d want 2", rs1_addr); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_out_valid got %b want 1", out_valid); end
        vectors++; if (alu_op !== 16'h0013) begin miscompares++; $display("FAIL addi_alu_op got %h want 0013", alu_op); end
        vectors++; if (alu_a !== 32'd10 || alu_b !== 32'd5) begin miscompares++; $display("FAIL addi_operands got %0d/%0d want 10/5", alu_a, alu_b); end
        vectors++; if (rd_addr !== 5'd1 || rd_we !== 1'b1 || alu_e !== 1'b1) begin miscompares++; $display("FAIL addi_rd got rd=%0d we=%b e=%b want 1/1/1", rd_addr, rd_we, alu_e); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_sub();
        in_valid = 1'b1; in_instr = 32'h402081B3; rs1_data = 32'd7; rs2_data = 32'd3;
        tick();
        in_valid = 1'b0;
        vectors++; if (alu_op !== 16'h8033) begin miscompares++; $display("FAIL sub_alu_op got %h want 8033", alu_op); end
        vectors++; if (alu_a !== 32'd7 || alu_b !== 32'd3) begin miscompares++; $display("FAIL sub_operands got %0d/%0d want 7/3", alu_a, alu_b); end
        vectors++; if (illegal !== 1'b0 || rd_addr !== 5'd3 || rd_we !== 1'b1) begin miscompares++; $display("FAIL sub_ctrl got ill=%b rd=%0d we=%b want 0/3/1", illegal, rd_addr, rd_we); end
        tick();
    endtask

    task automatic test_srai_lui();
        // srai x5, x6, 3
        in_valid = 1'b1; in_instr = 32'h40335293; rs1_data = 32'h80000000; rs2_data = 32'h0;
        tick();
        // lui x7, 0x12345 offered while srai is issued
        in_instr = 32'h123453B7; rs1_data = 32'hDEADBEEF;
        vectors++; if (alu_op !== 16'h8293 || alu_a !== 32'h80000000 || alu_b !== 32'd3) begin miscompares++; $display("FAIL srai got op=%h a=%h b=%h want 8293/80000000/3", alu_op, alu_a, alu_b); end
        tick();
        in_valid = 1'b0;
        vectors++; if (alu_op !== 16'h0037 || alu_a !== 32'h0 || alu_b !== 32'h12345000) begin miscompares++; $display("FAIL lui got op=%h a=%h b=%h want 0037/0/12345000", alu_op, alu_a, alu_b); end
        vectors++; if (rd_addr !== 5'd7 || rd_we !== 1'b1) begin miscompares++; $display("FAIL lui_rd got rd=%0d we=%b want 7/1", rd_addr, rd_we); end
        tick();
    endtask

    task automatic test_branch();
        // beq x1, x2, -8 at pc 0x100
        in_valid = 1'b1; in_instr = 32'hFE208CE3; in_pc = 32'h100; rs1_data = 32'h55; rs2_data = 32'hAA;
        tick();
        in_valid = 1'b0;
        vectors++; if (is_branch !== 1'b1 || rd_we !== 1'b0) begin miscompares++; $display("FAIL beq_ctrl got br=%b we=%b want 1/0", is_branch, rd_we); end
        vectors++; if (alu_a !== 32'h100 || alu_b !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL beq_operands got %h/%h want 00000100/fffffff8", alu_a, alu_b); end
        vectors++; if (cmp_a !== 32'h55 || cmp_b !== 32'hAA) begin miscompares++; $display("FAIL beq_cmp got %h/%h want 55/aa", cmp_a, cmp_b); end
        vectors++; if (alu_op !== 16'h0063 || out_pc !== 32'h100) begin miscompares++; $display("FAIL beq_op_pc got %h/%h want 0063/100", alu_op, out_pc); end
        tick();
        in_pc = 32'h0;
    endtask

    task automatic test_illegal();
        logic [31:0] bad_instr [3];
        bad_instr[0] = 32'hFFFFFFFF;  // unknown opcode
        bad_instr[1] = 32'h4020F1B3;  // AND with funct7 0x20
        bad_instr[2] = 32'h40111093;  // SLLI with funct7 0x20
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = bad_instr[i]; rs1_data = 32'h1; rs2_data = 32'h2;
            tick();
            in_valid = 1'b0;
            vectors++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_%0d_flag got v=%b ill=%b want 1/1", i, out_valid, illegal); end
            vectors++; if (alu_e !== 1'b0 || rd_we !== 1'b0 || alu_op !== 16'h0) begin miscompares++; $display("FAIL illegal_%0d_ctrl got e=%b we=%b op=%h want 0/0/0000", i, alu_e, rd_we, alu_op); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        rs1_data = 32'h0; rs2_data = 32'h0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093;  // addi x1,x0,1
        tick();
        in_instr = 32'h00200113;                   // addi x2,x0,2
        tick();
        in_instr = 32'h00300193;                   // addi x3,x0,3
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_b !== 32'd1 || rd_addr !== 5'd1) begin miscompares++; $display("FAIL bp_hold got v=%b b=%0d rd=%0d want 1/1/1", out_valid, alu_b, rd_addr); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_still_full got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        vectors++; if (alu_b !== 32'd2 || rd_addr !== 5'd2 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_second got b=%0d rd=%0d rdy=%b want 2/2/1", alu_b, rd_addr, in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || alu_b !== 32'd3 || rd_addr !== 5'd3) begin miscompares++; $display("FAIL bp_third got v=%b b=%0d rd=%0d want 1/3/3", out_valid, alu_b, rd_addr); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; rs1_data = 32'h0;
        in_valid = 1'b1; in_instr = 32'h00100093;
        tick();
        in_instr = 32'h00200113;
        tick();
        in_instr = 32'h00300193; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        vectors++; if (out_valid !== 1'b0 || alu_e !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got v=%b e=%b want 0/0", out_valid, alu_e); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got %b want 0", out_valid); end
        in_valid = 1'b1; in_instr = 32'h00510093; rs1_data = 32'd20;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || alu_a !== 32'd20 || alu_b !== 32'd5) begin miscompares++; $display("FAIL flush_resume got v=%b a=%0d b=%0d want 1/20/5", out_valid, alu_a, alu_b); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h402081B3; rs1_data = 32'd7; rs2_data = 32'd3;
        tick();
        in_instr = 32'h00510093;
        tick();
        reset = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got v=%b rdy=%b want 0/0", out_valid, in_ready); end
        vectors++; if (alu_op !== 16'h0 || alu_a !== 32'h0 || alu_b !== 32'h0 || rd_we !== 1'b0 || rd_addr !== 5'd0) begin miscompares++; $display("FAIL midreset_data got op=%h a=%h b=%h we=%b rd=%0d want all 0", alu_op, alu_a, alu_b, rd_we, rd_addr); end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_after got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub();
        test_srai_lui();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
